// File: rtl/decode_stage_if.sv
// decode_stage_if: instruction/writeback inputs and decoded field/control outputs of the ID stage.
interface decode_stage_if #(
    parameter int DATA = 32,
    parameter int AW   = 5
);
    logic            writeEnable;
    logic [31:0]     instruction;
    logic [DATA-1:0] writeData;
    logic [AW-1:0]   writeReg;
    logic [DATA-1:0] immOut;
    logic [DATA-1:0] readData1;
    logic [DATA-1:0] readData2;
    logic [4:0]      rsOut;
    logic [4:0]      rtOut;
    logic [4:0]      destReg;
    logic [5:0]      opcode;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic            aluSrc;
    logic            branch;
    logic            jump;
    logic            halt;

    modport master (
        output writeEnable, instruction, writeData, writeReg,
        input  immOut, readData1, readData2, rsOut, rtOut, destReg, opcode,
               regWrite, memRead, memWrite, aluSrc, branch, jump, halt
    );
    modport slave (
        input  writeEnable, instruction, writeData, writeReg,
        output immOut, readData1, readData2, rsOut, rtOut, destReg, opcode,
               regWrite, memRead, memWrite, aluSrc, branch, jump, halt
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: MIPS-Lite ID stage -- field split, sign extension, 2R/1W register file with
// same-cycle writeback bypass, and opcode-to-control decode.
module decode_stage #(
    parameter int DATA  = 32,
    parameter int NREGS = 32
) (
    input logic          clk,
    input logic          rst_n,
    decode_stage_if.slave id
);
    localparam int AW = $clog2(NREGS);

    logic [DATA-1:0] regs [NREGS];
    logic [5:0]      op;
    logic [4:0]      rs, rt, rd;
    logic            wr_ok, r_type;

    assign op    = id.instruction[31:26];
    assign rs    = id.instruction[25:21];
    assign rt    = id.instruction[20:16];
    assign rd    = id.instruction[15:11];
    assign wr_ok = id.writeEnable && id.writeReg != '0;

    // R0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[id.writeReg] <= id.writeData;
        end
    end

    // Writeback in the same cycle is forwarded so ID sees the value WB is committing.
    assign id.readData1 = (rst_n && wr_ok && id.writeReg == AW'(rs)) ? id.writeData : regs[rs];
    assign id.readData2 = (rst_n && wr_ok && id.writeReg == AW'(rt)) ? id.writeData : regs[rt];

    assign id.immOut = {{(DATA-16){id.instruction[15]}}, id.instruction[15:0]};
    assign id.rsOut  = rs;
    assign id.rtOut  = rt;
    assign id.opcode = op;

    assign r_type      = !op[0] && op <= 6'h0A;
    assign id.destReg  = r_type ? rd : rt;
    assign id.aluSrc   = (op[0] && op <= 6'h0B) || op == 6'h0C || op == 6'h0D;
    assign id.regWrite = op <= 6'h0C;
    assign id.memRead  = op == 6'h0C;
    assign id.memWrite = op == 6'h0D;
    assign id.branch   = op == 6'h0E || op == 6'h0F;
    assign id.jump     = op == 6'h10;
    assign id.halt     = op == 6'h11;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage; expectations queued with stimulus, drained on sampling.
module tb_decode_stage;
    localparam int F_IMM = 0, F_RD1 = 1, F_RD2 = 2, F_RS = 3, F_RT = 4, F_DST = 5, F_OP = 6, F_CTL = 7;

    typedef struct {
        string       name;
        int          f;
        logic [31:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [31:0] ref_regs [32];

    decode_stage_if dif ();
    decode_stage dut (.clk(clk), .rst_n(rst_n), .id(dif));

    always #5 clk = ~clk;

    // {regWrite,memRead,memWrite,aluSrc,branch,jump,halt}
    logic [5:0] c_op  [11] = '{6'h00, 6'h01, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h11, 6'h3F};
    logic [6:0] c_ctl [11] = '{7'b1000000, 7'b1001000, 7'b1000000, 7'b1001000, 7'b1101000, 7'b0011000,
                               7'b0000100, 7'b0000100, 7'b0000010, 7'b0000001, 7'b0000000};
    logic [4:0] c_dst [11] = '{5'd3, 5'd2, 5'd3, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2};

    function automatic logic [31:0] obs(int f);
        case (f)
            F_IMM:   return dif.immOut;
            F_RD1:   return dif.readData1;
            F_RD2:   return dif.readData2;
            F_RS:    return {27'd0, dif.rsOut};
            F_RT:    return {27'd0, dif.rtOut};
            F_DST:   return {27'd0, dif.destReg};
            F_OP:    return {26'd0, dif.opcode};
            default: return {25'd0, dif.regWrite, dif.memRead, dif.memWrite, dif.aluSrc,
                             dif.branch, dif.jump, dif.halt};
        endcase
    endfunction

    function automatic logic [31:0] ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        @(negedge clk);
        dif.writeEnable = 1'b1;
        dif.writeReg    = r;
        dif.writeData   = d;
        @(posedge clk);
        #1 dif.writeEnable = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n = 1'b0;
        dif.instruction = ins(6'h01, 5'd5, 5'd6, 16'h8001);
        dif.writeEnable = 1'b1;
        dif.writeReg    = 5'd5;
        dif.writeData   = 32'hA5A5A5A5;
        #2;
        sb.push_back('{"rst_rd1_no_bypass", F_RD1, 32'h0});
        sb.push_back('{"rst_rd2", F_RD2, 32'h0});
        sb.push_back('{"rst_imm_comb", F_IMM, 32'hFFFF8001});
        sb.push_back('{"rst_ctl_comb", F_CTL, 32'h48});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
        dif.writeEnable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addi;
        exp_t e;
        @(negedge clk);
        dif.instruction = 32'h040103E8;
        #1;
        sb.push_back('{"addi_imm", F_IMM, 32'h000003E8});
        sb.push_back('{"addi_rd1", F_RD1, 32'h0});
        sb.push_back('{"addi_ctl", F_CTL, 32'h48});
        sb.push_back('{"addi_dst", F_DST, 32'd1});
        sb.push_back('{"addi_rs", F_RS, 32'd0});
        sb.push_back('{"addi_rt", F_RT, 32'd1});
        sb.push_back('{"addi_op", F_OP, 32'h01});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
    endtask

    task automatic test_write;
        exp_t e;
        wr(5'd5, 32'hDEADBEEF);
        dif.instruction = ins(6'h00, 5'd5, 5'd0, 16'h0);
        #1;
        sb.push_back('{"write_r5", F_RD1, 32'hDEADBEEF});
        sb.push_back('{"write_r0_base", F_RD2, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
        @(negedge clk);
        dif.instruction = ins(6'h00, 5'd0, 5'd5, 16'h0);
        dif.writeEnable = 1'b1;
        dif.writeReg    = 5'd0;
        dif.writeData   = 32'hFFFFFFFF;
        #1;
        sb.push_back('{"r0_no_bypass", F_RD1, 32'h0});
        sb.push_back('{"r5_kept", F_RD2, 32'hDEADBEEF});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
        @(posedge clk);
        #1 dif.writeEnable = 1'b0;
        sb.push_back('{"r0_after_write", F_RD1, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
    endtask

    task automatic test_bypass;
        exp_t e;
        @(negedge clk);
        dif.instruction = ins(6'h00, 5'd5, 5'd7, 16'h0);
        dif.writeEnable = 1'b1;
        dif.writeReg    = 5'd7;
        dif.writeData   = 32'h12345678;
        #1;
        sb.push_back('{"bypass_rd2", F_RD2, 32'h12345678});
        sb.push_back('{"bypass_rd1_other", F_RD1, 32'hDEADBEEF});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
        @(posedge clk);
        #1 dif.writeEnable = 1'b0;
        dif.writeData = 32'h0;
        #1;
        sb.push_back('{"bypass_committed", F_RD2, 32'h12345678});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
    endtask

    task automatic test_imm_rtype;
        exp_t e;
        @(negedge clk);
        dif.instruction = 32'h0422FFFF;
        #1;
        sb.push_back('{"neg_imm", F_IMM, 32'hFFFFFFFF});
        sb.push_back('{"neg_dst", F_DST, 32'd2});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
        dif.instruction = 32'h00432000;
        #1;
        sb.push_back('{"add_dst", F_DST, 32'd4});
        sb.push_back('{"add_ctl", F_CTL, 32'h40});
        sb.push_back('{"add_imm", F_IMM, 32'h00002000});
        sb.push_back('{"add_rs", F_RS, 32'd2});
        sb.push_back('{"add_rt", F_RT, 32'd3});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
    endtask

    task automatic test_control;
        exp_t e;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            dif.instruction = ins(c_op[k], 5'd1, 5'd2, {5'd3, 11'd0});
            #1;
            sb.push_back('{$sformatf("ctl_op%02h", c_op[k]), F_CTL, {25'd0, c_ctl[k]}});
            sb.push_back('{$sformatf("dst_op%02h", c_op[k]), F_DST, {27'd0, c_dst[k]}});
            sb.push_back('{$sformatf("opc_op%02h", c_op[k]), F_OP, {26'd0, c_op[k]}});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.f) !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
                end
            end
        end
    endtask

    task automatic test_reset_midrun;
        exp_t e;
        wr(5'd9, 32'hCAFEF00D);
        dif.instruction = ins(6'h00, 5'd9, 5'd7, 16'h0);
        #1;
        sb.push_back('{"pre_rst_r9", F_RD1, 32'hCAFEF00D});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
        rst_n = 1'b0;
        #1;
        sb.push_back('{"async_rst_r9", F_RD1, 32'h0});
        sb.push_back('{"async_rst_r7", F_RD2, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (obs(e.f) !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
            end
        end
        for (int r = 0; r < 32; r++) begin
            dif.instruction = ins(6'h00, 5'(r), 5'(31 - r), 16'h0);
            #1;
            sb.push_back('{$sformatf("rst_sweep_r%0d", r), F_RD1, 32'h0});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.f) !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [4:0]  r, t;
        logic [31:0] d;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            r = 5'($urandom_range(0, 31));
            t = (k % 3 == 0) ? r : 5'($urandom_range(0, 31));
            d = $urandom;
            dif.writeEnable = 1'b1;
            dif.writeReg    = r;
            dif.writeData   = d;
            dif.instruction = ins(6'h00, r, t, 16'h0);
            #1;
            sb.push_back('{$sformatf("b2b_rd1_%0d", k), F_RD1, (r == 5'd0) ? 32'h0 : d});
            sb.push_back('{$sformatf("b2b_rd2_%0d", k), F_RD2, (t == r && r != 5'd0) ? d : ref_regs[t]});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.f) !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
                end
            end
            @(posedge clk);
            if (r != 5'd0) ref_regs[r] = d;
        end
        #1 dif.writeEnable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dif.instruction = ins(6'h00, 5'(i), 5'(i), 16'h0);
            #1;
            sb.push_back('{$sformatf("b2b_final_r%0d", i), F_RD1, ref_regs[i]});
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs(e.f) !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.f), e.v);
                end
            end
        end
    endtask

    initial begin
        dif.writeEnable = 1'b0;
        dif.writeReg    = 5'd0;
        dif.writeData   = 32'h0;
        dif.instruction = 32'h0;
        test_reset();
        test_addi();
        test_write();
        test_bypass();
        test_imm_rtype();
        test_control();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
